// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of every hazard-controller signal other than clock and reset.
//   master : pipeline side. Drives the hazard sources and consumes the
//            stall/flush/pc_write controls, halted and stall_cycles.
//   slave  : hazard_ctrl side. Reads the hazard sources and drives the
//            controls.
// Parameter CNT_W sets the width of stall_cycles and must match the
// controller's CNT_W.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard sources
    logic [1:0]       rs_ID;
    logic [1:0]       rt_ID;
    logic             use_rs_ID;
    logic             use_rt_ID;
    logic             RegWrite_EX;
    logic             d_readM_EX;
    logic [1:0]       write_reg_addr_EX;
    logic             RegWrite_MEM;
    logic [1:0]       write_reg_addr_MEM;
    logic             d_req_MEM;
    logic             d_ready;
    logic             i_ready;
    logic             jump_mispredict_ID;
    logic             branch_mispredict_EX;
    logic             is_halted_WB;
    // Pipeline controls
    logic             pc_write;
    logic             stall_IF_ID;
    logic             stall_ID_EX;
    logic             stall_EX_MEM;
    logic             stall_MEM_WB;
    logic             flush_IF_ID;
    logic             flush_ID_EX;
    logic             flush_EX_MEM;
    logic             flush_MEM_WB;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rs_ID, rt_ID, use_rs_ID, use_rt_ID, RegWrite_EX, d_readM_EX,
               write_reg_addr_EX, RegWrite_MEM, write_reg_addr_MEM, d_req_MEM,
               d_ready, i_ready, jump_mispredict_ID, branch_mispredict_EX,
               is_halted_WB,
        input  pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted,
               stall_cycles
    );

    modport slave (
        input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, RegWrite_EX, d_readM_EX,
               write_reg_addr_EX, RegWrite_MEM, write_reg_addr_MEM, d_req_MEM,
               d_ready, i_ready, jump_mispredict_ID, branch_mispredict_EX,
               is_halted_WB,
        output pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted,
               stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and stall controller for the 16-bit 5-stage TSC core.
// It drives stall/flush for IF_ID, ID_EX, EX_MEM and MEM_WB and the PC write
// enable. It discards a wrong-path fetch that returns after a redirect (DROP
// state). It holds the core once HLT retires (HALT state). It also keeps a
// saturating count of stalled cycles.
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous, active-low reset
//   hz       : hazard_ctrl_if.slave. Hazard sources in; stall_*, flush_*,
//              pc_write, halted and stall_cycles out.
// Parameters:
//   CNT_W    : stall_cycles width (default 16)
// Configuration macro:
//   FORWARDING_EN : when defined, only load-use is a RAW hazard (the EX/MEM
//                   forwarding paths are active). When undefined, any
//                   EX or MEM producer of an ID source is a RAW hazard.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DROP = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    // Control vectors ordered {IF_ID, ID_EX, EX_MEM, MEM_WB}
    logic [3:0] stall_v;
    logic [3:0] flush_v;
    logic       pc_write;

    logic dep_ex;
    logic load_use;
    logic raw;
    logic dmem_wait;

    assign dep_ex = (hz.use_rs_ID && (hz.rs_ID == hz.write_reg_addr_EX)) ||
                    (hz.use_rt_ID && (hz.rt_ID == hz.write_reg_addr_EX));
    assign load_use  = hz.d_readM_EX && hz.RegWrite_EX && dep_ex;
    assign dmem_wait = hz.d_req_MEM && !hz.d_ready;

`ifdef FORWARDING_EN
    assign raw = load_use;
`else
    logic dep_mem;
    assign dep_mem = (hz.use_rs_ID && (hz.rs_ID == hz.write_reg_addr_MEM)) ||
                     (hz.use_rt_ID && (hz.rt_ID == hz.write_reg_addr_MEM));
    // WB producers are never hazards: the register file writes in the
    // first half-cycle.
    assign raw = (hz.RegWrite_EX && dep_ex) || (hz.RegWrite_MEM && dep_mem);
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d  = state_q;
        stall_v  = 4'b0000;
        flush_v  = 4'b0000;
        pc_write = 1'b0;

        if (!reset_n) begin
            flush_v = 4'b1111;
        end else if (state_q == HALT || hz.is_halted_WB) begin
            // The HLT is already in WB, so it beats a pending data-memory wait.
            stall_v = 4'b1111;
            state_d = HALT;
        end else if (dmem_wait) begin
            // Freeze everything upstream of MEM. Mispredict flags stay asserted
            // while their stages are held, so they are acted on later.
            stall_v = 4'b1110;
            flush_v = 4'b0001;
        end else if (hz.branch_mispredict_EX) begin
            flush_v  = 4'b1100;
            pc_write = 1'b1;
            if (!hz.i_ready) state_d = DROP;
        end else if (raw) begin
            stall_v = 4'b1000;
            flush_v = 4'b0100;
        end else if (hz.jump_mispredict_ID) begin
            flush_v  = 4'b1000;
            pc_write = 1'b1;
            if (!hz.i_ready) state_d = DROP;
        end else if (!hz.i_ready) begin
            flush_v = 4'b1000;
        end else if (state_q == DROP) begin
            // The word arriving now belongs to the abandoned path.
            flush_v = 4'b1000;
            state_d = RUN;
        end else begin
            pc_write = 1'b1;
        end
    end

    always_comb begin
        halted_d       = (state_d == HALT);
        stall_cycles_d = stall_cycles_q;
        if (state_q != HALT && !hz.is_halted_WB && !pc_write &&
            stall_cycles_q != {CNT_W{1'b1}}) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            state_q        <= RUN;
            halted_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            halted_q       <= halted_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.stall_IF_ID  = stall_v[3];
    assign hz.stall_ID_EX  = stall_v[2];
    assign hz.stall_EX_MEM = stall_v[1];
    assign hz.stall_MEM_WB = stall_v[0];
    assign hz.flush_IF_ID  = flush_v[3];
    assign hz.flush_ID_EX  = flush_v[2];
    assign hz.flush_EX_MEM = flush_v[1];
    assign hz.flush_MEM_WB = flush_v[0];
    assign hz.halted       = halted_q;
    assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. A small CNT_W keeps the saturation
// case short. Inputs change 1 time unit after the rising edge. Expected
// results are queued per cycle and compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    localparam int CNT_W = 4;
`ifdef FORWARDING_EN
    localparam int NF = 0;
`else
    localparam int NF = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
    hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .hz(hz));

    typedef struct {
        string            tag;
        logic [9:0]       o;
        logic [CNT_W-1:0] cnt;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int e_cnt  = 0;

    logic [9:0] obs;
    assign obs = {hz.pc_write, hz.stall_IF_ID, hz.stall_ID_EX, hz.stall_EX_MEM,
                  hz.stall_MEM_WB, hz.flush_IF_ID, hz.flush_ID_EX,
                  hz.flush_EX_MEM, hz.flush_MEM_WB, hz.halted};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {pc_write, stall[IF_ID..MEM_WB], flush[IF_ID..MEM_WB], halted}
    function automatic logic [9:0] outs(input logic pc, input logic [3:0] s,
                                        input logic [3:0] f, input logic h);
        return {pc, s, f, h};
    endfunction

    logic [9:0] NORM, RST_O, LU_O, BR_O, DW_O, JMP_O, FET_O, HLT0_O, HLT1_O, RSTH_O;

    task automatic idle();
        hz.rs_ID = 2'd0; hz.rt_ID = 2'd0; hz.use_rs_ID = 1'b0; hz.use_rt_ID = 1'b0;
        hz.RegWrite_EX = 1'b0; hz.d_readM_EX = 1'b0; hz.write_reg_addr_EX = 2'd0;
        hz.RegWrite_MEM = 1'b0; hz.write_reg_addr_MEM = 2'd0;
        hz.d_req_MEM = 1'b0; hz.d_ready = 1'b0; hz.i_ready = 1'b1;
        hz.jump_mispredict_ID = 1'b0; hz.branch_mispredict_EX = 1'b0;
        hz.is_halted_WB = 1'b0;
    endtask

    task automatic load_use();
        hz.d_readM_EX = 1'b1; hz.RegWrite_EX = 1'b1; hz.write_reg_addr_EX = 2'd1;
        hz.rs_ID = 2'd1; hz.use_rs_ID = 1'b1;
    endtask

    // Queue the expectation for the current cycle, compare it mid-cycle,
    // then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [9:0] o, input int c);
        exp_t e;
        exp_t pushed;
        pushed.tag = tag;
        pushed.o   = o;
        pushed.cnt = c[CNT_W-1:0];
        sb.push_back(pushed);
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".out"}, 32'(obs), 32'(e.o));
        check({e.tag, ".cnt"}, 32'(hz.stall_cycles), 32'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        NORM   = outs(1'b1, 4'b0000, 4'b0000, 1'b0);
        RST_O  = outs(1'b0, 4'b0000, 4'b1111, 1'b0);
        RSTH_O = outs(1'b0, 4'b0000, 4'b1111, 1'b1);
        LU_O   = outs(1'b0, 4'b1000, 4'b0100, 1'b0);
        BR_O   = outs(1'b1, 4'b0000, 4'b1100, 1'b0);
        DW_O   = outs(1'b0, 4'b1110, 4'b0001, 1'b0);
        JMP_O  = outs(1'b1, 4'b0000, 4'b1000, 1'b0);
        FET_O  = outs(1'b0, 4'b0000, 4'b1000, 1'b0);
        HLT0_O = outs(1'b0, 4'b1111, 4'b0000, 1'b0);
        HLT1_O = outs(1'b0, 4'b1111, 4'b0000, 1'b1);

        reset_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        cyc("reset", RST_O, 0);
        reset_n = 1'b1;
        cyc("idle", NORM, 0);

        // Load-use: one bubble, counter 0 -> 1
        load_use();
        cyc("load_use", LU_O, e_cnt); e_cnt++;
        idle();
        cyc("after_lu", NORM, e_cnt);

        // Branch mispredict beats load-use
        load_use(); hz.branch_mispredict_EX = 1'b1;
        cyc("br_lu", BR_O, e_cnt);

        // Data-memory wait with a branch mispredict held for 3 cycles
        idle(); hz.d_req_MEM = 1'b1; hz.branch_mispredict_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("dwait%0d", i), DW_O, e_cnt); e_cnt++;
        end
        hz.d_ready = 1'b1;
        cyc("dwait_done", BR_O, e_cnt);
        idle();
        cyc("idle2", NORM, e_cnt);

        // Jump mispredict with outstanding fetch -> DROP, word discarded
        hz.jump_mispredict_ID = 1'b1; hz.i_ready = 1'b0;
        cyc("jmp_drop", JMP_O, e_cnt);
        idle(); hz.i_ready = 1'b0;
        cyc("drop_wait", FET_O, e_cnt); e_cnt++;
        hz.i_ready = 1'b1;
        cyc("drop_word", FET_O, e_cnt); e_cnt++;
        cyc("drop_run", NORM, e_cnt);

        // Jump suppressed by RAW
        load_use(); hz.jump_mispredict_ID = 1'b1;
        cyc("jmp_raw", LU_O, e_cnt); e_cnt++;

        // MEM-stage producer: hazard only without forwarding
        idle(); hz.RegWrite_MEM = 1'b1; hz.write_reg_addr_MEM = 2'd2;
        hz.rt_ID = 2'd2; hz.use_rt_ID = 1'b1;
        cyc("mem_dep", NF ? LU_O : NORM, e_cnt); e_cnt += NF;

        // Non-load EX producer: hazard only without forwarding
        idle(); hz.RegWrite_EX = 1'b1; hz.write_reg_addr_EX = 2'd3;
        hz.rs_ID = 2'd3; hz.use_rs_ID = 1'b1;
        cyc("ex_dep", NF ? LU_O : NORM, e_cnt); e_cnt += NF;

        // Unused source field does not create a hazard
        idle(); hz.RegWrite_EX = 1'b1; hz.write_reg_addr_EX = 2'd3; hz.rt_ID = 2'd3;
        cyc("no_use", NORM, e_cnt);

        // Redirect while in DROP keeps DROP
        idle(); hz.jump_mispredict_ID = 1'b1; hz.i_ready = 1'b0;
        cyc("jmp_drop2", JMP_O, e_cnt);
        idle(); hz.branch_mispredict_EX = 1'b1; hz.i_ready = 1'b0;
        cyc("br_in_drop", BR_O, e_cnt);
        idle();
        cyc("drop2_word", FET_O, e_cnt); e_cnt++;
        cyc("drop2_run", NORM, e_cnt);

        // Halt wins over a data-memory wait; outputs frozen afterwards
        hz.is_halted_WB = 1'b1; hz.d_req_MEM = 1'b1;
        cyc("halt_entry", HLT0_O, e_cnt);
        idle();
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("halt%0d", i), HLT1_O, e_cnt);
        end
        load_use(); hz.branch_mispredict_EX = 1'b1;
        cyc("halt_sticky", HLT1_O, e_cnt);

        // Reset out of HALT
        idle(); reset_n = 1'b0;
        cyc("halt_reset", RSTH_O, e_cnt);
        reset_n = 1'b1;
        cyc("post_reset", NORM, 0);

        // Counter saturation with a starving fetch
        hz.i_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            cyc($sformatf("sat%0d", i), FET_O, (i > 15) ? 15 : i);
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline hazard and stall controller for the 16-bit, 5-stage TSC pipeline. It drives the stall and flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, and it drives the PC write enable. Its decisions come from:
- register dependencies,
- memory handshakes,
- control-flow mispredictions,
- halt retirement.

It holds a small FSM so that a wrong-path instruction fetch still in flight during a redirect is discarded. It also keeps a stall statistics counter.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- rs_ID, rt_ID  in  2 each  source registers of the instruction in ID
- use_rs_ID, use_rt_ID  in  1 each  the ID instruction reads rs / rt
- RegWrite_EX, d_readM_EX  in  1 each  EX-stage write-back and load flags
- write_reg_addr_EX  in  2  EX-stage destination register
- RegWrite_MEM  in  1  MEM-stage write-back flag
- write_reg_addr_MEM  in  2  MEM-stage destination register
- d_req_MEM  in  1  MEM stage has a data read or write outstanding
- d_ready  in  1  data memory has completed the access
- i_ready  in  1  instruction memory has delivered the fetch word this cycle
- jump_mispredict_ID  in  1  jump in ID resolved to a PC different from the predicted PC
- branch_mispredict_EX  in  1  branch in EX resolved against its prediction
- is_halted_WB  in  1  HLT instruction is in WB
- pc_write  out  1  PC register update enable
- stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB  out  1 each  hold the pipeline register
- flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  load a bubble into the pipeline register
- halted  out  1  core has halted (registered)
- stall_cycles  out  CNT_W  number of RUN/DROP cycles with pc_write=0, saturating

## Operation
- FSM states:
  - RUN: normal operation.
  - DROP: a redirect happened while a fetch was outstanding; the returning word is wrong-path.
  - HALT: terminal state.
- Hazard terms:
  - dep(a) = (use_rs_ID & rs_ID==a) | (use_rt_ID & rt_ID==a).
  - load_use = d_readM_EX & RegWrite_EX & dep(write_reg_addr_EX).
  - redirect = branch_mispredict_EX | (jump_mispredict_ID & ~raw).
- Decision priority in RUN and DROP, first matching rule wins; unlisted outputs are 0:
  1. dmem_wait = d_req_MEM & ~d_ready. Drive all four stall_*=1 except stall_MEM_WB=0, flush_MEM_WB=1, pc_write=0. Mispredict inputs are ignored and re-sampled later, because the signals stay asserted while their stages are held.
  2. branch_mispredict_EX. Drive flush_IF_ID=1, flush_ID_EX=1, pc_write=1.
  3. raw (load_use, or the wider hazard set under configuration). Drive pc_write=0, stall_IF_ID=1, flush_ID_EX=1. A jump mispredict in ID is suppressed this cycle.
  4. jump_mispredict_ID. Drive flush_IF_ID=1, pc_write=1.
  5. Fetch handling:
     - ~i_ready: flush_IF_ID=1, pc_write=0.
     - i_ready in DROP: flush_IF_ID=1, pc_write=0, then go to RUN.
     - Otherwise: pc_write=1.
- FSM transitions:
  - RUN→DROP when redirect fires (rule 2 or 4) and i_ready=0.
  - A redirect while already in DROP stays in DROP, with pc_write=1.
  - Any state→HALT when is_halted_WB=1; HALT takes precedence over all other rules.
- HALT outputs:
  - All stall_*=1, all flush_*=0, pc_write=0.
  - halted=1 from the cycle after entry.
  - Exit only through reset.
- stall_cycles:
  - Increments by 1 in RUN/DROP on every cycle with pc_write=0.
  - Holds at 2^CNT_W-1.
  - Frozen in HALT.
- The register file writes in the first half-cycle, so a WB-stage producer never counts as a hazard.

## Timing
- The stall, flush and pc_write outputs are combinational from the current state and inputs. They take effect at the next rising edge.
- state and halted update on the rising edge.
- Load-use costs exactly 1 bubble: the cycle after the stall, the load is in MEM and the consumer is satisfied through forwarding.
- Branch mispredict costs 2 bubbles. Jump mispredict costs 1 bubble.
- Data-memory wait costs 1 frozen cycle per cycle with d_ready=0. The cycle in which d_ready=1 proceeds normally.
- Simultaneous dmem_wait and is_halted_WB: HALT wins, because the HLT is already in WB.
- Reset (reset_n=0 at an edge):
  - Next state is RUN, halted=0, stall_cycles=0.
  - Combinational outputs while reset_n=0: all flush_*=1, all stall_*=0, pc_write=0.
  - Reset asserted mid-DROP or mid-HALT also returns the FSM to RUN.

## Configuration
- FORWARDING_EN defined:
  - raw = load_use only.
  - The EX/MEM forwarding paths in the datapath are active.
- FORWARDING_EN undefined:
  - raw = (RegWrite_EX & dep(write_reg_addr_EX)) | (RegWrite_MEM & dep(write_reg_addr_MEM)).
  - A dependent instruction stalls in ID for up to 2 cycles, until its producer reaches WB.

## Test plan
- Load-use: LWD $1 in EX (d_readM_EX=1, RegWrite_EX=1, write_reg_addr_EX=1), ADD in ID reading rs=1 -> for 1 cycle pc_write=0, stall_IF_ID=1, flush_ID_EX=1; stall_cycles goes from 0 to 1.
- Branch mispredict together with load_use -> flush_IF_ID=1, flush_ID_EX=1, pc_write=1, stall_IF_ID=0.
- d_req_MEM=1 with d_ready=0 for 3 cycles, branch_mispredict_EX=1 throughout -> 3 cycles with stalls on IF_ID/ID_EX/EX_MEM and flush_MEM_WB=1; on the 4th cycle (d_ready=1) the redirect fires.
- Jump mispredict with i_ready=0, then i_ready=1 two cycles later -> state DROP, and the returning word is flushed with pc_write=0; the next cycle returns to RUN with pc_write=1.
- is_halted_WB=1 -> halted=1 on the next edge; all stall_*=1 and pc_write=0 for 10 further cycles; stall_cycles is unchanged. Then reset_n=0 for 1 cycle -> halted=0 and stall_cycles=0.
- FORWARDING_EN undefined, RegWrite_MEM=1, write_reg_addr_MEM=2, rt_ID=2, use_rt_ID=1 -> stall for 1 cycle; with the macro defined -> no stall.
